// File: rtl/mem_access_stage_v2.sv
// mem_access_stage_v2: MEM stage with variable-latency dmem handshake.
// Lane-steered stores, extended loads, misalignment trap.
module mem_access_stage_v2 #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_WB   = 8,
  parameter int NB_MEM  = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_ADDR-1:0]   i_alu_o,
  input  logic [NB_DATA-1:0]   i_b_o,
  input  logic [NB_MEM-1:0]    i_mem,
  input  logic [NB_WB-1:0]     i_wb,
  input  logic [NB_ADDR-1:0]   i_pc,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [NB_ADDR-1:0]   o_reg_wb,
  output logic [NB_DATA-1:0]   o_ext_mem_o,
  output logic [NB_WB-1:0]     o_wb,
  output logic [NB_ADDR-1:0]   o_pc,
  output logic                 o_exc_misaligned,
  output logic                 o_dmem_req,
  output logic [NB_ADDR-1:0]   o_dmem_addr,
  output logic [NB_DATA-1:0]   o_dmem_wdata,
  output logic [NB_DATA/8-1:0] o_dmem_be,
  input  logic                 i_dmem_ack,
  input  logic [NB_DATA-1:0]   i_dmem_rdata
);

  localparam int NBYTE = NB_DATA / 8;
  localparam int OFFW  = $clog2(NBYTE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic                 req_q;
  logic                 valid_q;
  logic                 exc_q;
  logic [NB_ADDR-1:0]   reg_wb_q;
  logic [NB_DATA-1:0]   ext_q;
  logic [NB_WB-1:0]     wb_q;
  logic [NB_ADDR-1:0]   pc_q;

  // captured request
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB_DATA-1:0]   wdata_q;
  logic [NBYTE-1:0]     be_q;
  logic                 su_q;
  logic [1:0]           dsize_q;
  logic                 st_q;
  logic [NB_WB-1:0]     cwb_q;
  logic [NB_ADDR-1:0]   cpc_q;

  logic                 re_w;
  logic                 we_w;
  logic                 su_w;
  logic [1:0]           ds_w;
  logic                 acc_w;

  assign re_w  = i_mem[NB_MEM-1];
  assign we_w  = i_mem[NB_MEM-2];
  assign su_w  = i_mem[2];
  assign ds_w  = i_mem[1:0];
  assign acc_w = re_w | we_w;

  int                   sz_in;
  int                   off_in;
  logic                 mis_d;
  logic [NB_DATA-1:0]   wdata_d;
  logic [NBYTE-1:0]     be_d;

  // alignment check, store replication and byte-enable mask
  always_comb begin
    sz_in   = 1 << ds_w;
    off_in  = int'(i_alu_o[OFFW-1:0]);
    mis_d   = (sz_in > NBYTE) ||
              ((off_in & (sz_in - 1)) != 0);
    wdata_d = '0;
    be_d    = '0;
    for (int i = 0; i < NBYTE; i++) begin
      wdata_d[i*8 +: 8] = i_b_o[(i % sz_in)*8 +: 8];
      be_d[i] = we_w && (i >= off_in) &&
                (i < off_in + sz_in);
    end
  end

  int                   sz_cap;
  int                   off_cap;
  int                   msb_cap;
  logic [NB_DATA-1:0]   shifted;
  logic [NB_DATA-1:0]   ext_d;

  // load extraction and extension from the captured request
  always_comb begin
    sz_cap  = 1 << dsize_q;
    off_cap = int'(addr_q[OFFW-1:0]);
    msb_cap = (sz_cap * 8 > NB_DATA) ?
              NB_DATA - 1 : sz_cap * 8 - 1;
    shifted = i_dmem_rdata >> (8 * off_cap);
    ext_d   = '0;
    if (!st_q) begin
      for (int j = 0; j < NB_DATA; j++) begin
        ext_d[j] = (j <= msb_cap) ? shifted[j] :
                   (~su_q & shifted[msb_cap]);
      end
    end
  end

  // FSM with registered MEM/WB and request outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      reg_wb_q <= '0;
      ext_q    <= '0;
      wb_q     <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      su_q     <= 1'b0;
      dsize_q  <= '0;
      st_q     <= 1'b0;
      cwb_q    <= '0;
      cpc_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (!acc_w) begin
              valid_q  <= 1'b1;
              exc_q    <= 1'b0;
              reg_wb_q <= i_alu_o;
              ext_q    <= '0;
              wb_q     <= i_wb;
              pc_q     <= i_pc;
            end else if (mis_d) begin
              valid_q  <= 1'b1;
              exc_q    <= 1'b1;
              reg_wb_q <= i_alu_o;
              ext_q    <= '0;
              wb_q     <= '0;
              pc_q     <= i_pc;
            end else begin
              state_q  <= BUSY;
              req_q    <= 1'b1;
              addr_q   <= i_alu_o;
              wdata_q  <= wdata_d;
              be_q     <= be_d;
              su_q     <= su_w;
              dsize_q  <= ds_w;
              st_q     <= we_w;
              cwb_q    <= i_wb;
              cpc_q    <= i_pc;
            end
          end
        end
        BUSY: begin
          if (i_dmem_ack) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            exc_q    <= 1'b0;
            reg_wb_q <= addr_q;
            ext_q    <= ext_d;
            wb_q     <= cwb_q;
            pc_q     <= cpc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_stall = req_q |
                   ((state_q == IDLE) & i_valid &
                    acc_w & ~mis_d);

  assign o_valid          = valid_q;
  assign o_reg_wb         = reg_wb_q;
  assign o_ext_mem_o      = ext_q;
  assign o_wb             = wb_q;
  assign o_pc             = pc_q;
  assign o_exc_misaligned = exc_q;
  assign o_dmem_req       = req_q;
  assign o_dmem_addr      = {addr_q[NB_ADDR-1:OFFW],
                             {OFFW{1'b0}}};
  assign o_dmem_wdata     = wdata_q;
  assign o_dmem_be        = be_q;

endmodule
